// File: rtl/csla_subtractor_16_seq.sv
// Sequential 16-bit subtractor: a - b - bin evaluated as a + ~b + ~bin, one
// carry-select nibble per clock, with valid/ready handshakes on both sides.

module csla_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [4:0] sum
);
    logic [4:0] c;

    // 4-bit ripple-carry adder; sum[4] is the carry out
    always_comb begin
        c   = '0;
        sum = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        sum[4] = c[4];
    end
endmodule

module csla_mux2 #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

module csla_subtractor_16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        zero,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int unsigned W  = 16;
    localparam int unsigned NW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  nb_q, nb_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [3:0]    bit_base;
    logic [NW-1:0] a_nib, nb_nib;
    logic [NW:0]   s0, s1, sel_sum;

    assign bit_base = {k_q, 2'b00};
    assign a_nib    = a_q[bit_base +: NW];
    assign nb_nib   = nb_q[bit_base +: NW];

    // Carry-select stage: both candidate sums, picked by the registered carry
    csla_rca4 u_rca_c0 (.a(a_nib), .b(nb_nib), .cin(1'b0), .sum(s0));
    csla_rca4 u_rca_c1 (.a(a_nib), .b(nb_nib), .cin(1'b1), .sum(s1));
    csla_mux2 #(.W(NW + 1)) u_sel (.d0(s0), .d1(s1), .sel(carry_q), .y(sel_sum));

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        carry_d     = carry_q;
        a_d         = a_q;
        nb_d        = nb_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    k_d     = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                diff_d[bit_base +: NW] = sel_sum[NW-1:0];
                carry_d = sel_sum[NW];
                k_d     = 2'(k_q + 2'd1);
                if (k_q == 2'd3) begin
                    state_d = DONE;
                    bout_d  = ~sel_sum[NW];
                    // nb_q holds ~b, so a[15]^b[15] is the inverted xor
                    ovf_d   = (a_q[W-1] ^ ~nb_q[W-1]) & (a_q[W-1] ^ sel_sum[NW-1]);
                    zero_d  = (diff_d == '0);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            nb_q        <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: doc/csla_subtractor_16_seq.md
# csla_subtractor_16_seq

Sequential 16-bit subtractor that computes a − b − bin as a + ~b + ~bin. It processes one 4-bit nibble per clock, using a carry-select nibble stage in which both candidate sums (carry 0 and carry 1) are formed and a 2:1 mux selects by the registered carry. It is the inverse-direction counterpart of the 16-bit carry-select adder and shares its ripple-carry and multiplexer building blocks. Operands enter and results leave through valid/ready handshakes, so it sits between a stimulus source and a result consumer in the arithmetic datapath.

## Interface
- No parameters. Width is fixed at 16 bits, split into four 4-bit nibbles.
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- a  input  16  Minuend. Sampled only on input handshake.
- b  input  16  Subtrahend. Sampled only on input handshake.
- bin  input  1  Borrow in. Sampled only on input handshake.
- in_valid  input  1  Source presents a, b and bin.
- in_ready  output  1  Block can accept operands. High only in IDLE.
- diff  output  16  Result a − b − bin, modulo 2^16.
- bout  output  1  Borrow out: 1 when a < b + bin (unsigned).
- ovf  output  1  Signed overflow of the two's-complement subtraction.
- zero  output  1  diff == 16'h0000.
- out_valid  output  1  Result registers hold a valid result.
- out_ready  input  1  Consumer accepts the result.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid at an edge, latch a, ~b and carry = ~bin; set nibble index k=0; go to BUSY.
  - BUSY: on each edge, compute nibble k and write it to diff[4k+3:4k]:
    - s0 = a_k + nb_k + 0 and s1 = a_k + nb_k + 1 (5-bit each).
    - Select s1 when carry=1, else s0.
    - Register the selected low 4 bits into diff; register its bit 4 into carry.
    - k increments each edge. After the edge that processes k=3, go to DONE.
  - DONE: out_valid=1. On out_ready at an edge, go to IDLE. Result registers keep their value.
- Flags, registered on the edge that processes k=3:
  - bout = ~carry_final.
  - ovf = (a[15] ^ b[15]) & (a[15] ^ diff[15]).
  - zero = (diff == 0).
- diff is built up nibble by nibble while in BUSY. Its intermediate contents are undefined to the consumer; only values presented with out_valid=1 are meaningful.
- in_valid while in BUSY or DONE is ignored (in_ready=0). The source must hold its operands until the handshake occurs.
- No input and output overlap: a new operation can be accepted only after the DONE → IDLE transition.
- Reset has priority over every other event, including reset asserted mid-operation. On the reset edge: state=IDLE, k=0, carry=0, diff=0, bout=0, ovf=0, zero=0, out_valid=0, in_ready=1. Any operation in flight is discarded and no out_valid is produced for it.

## Timing
- Input handshake at edge T (in_valid & in_ready).
- Nibbles 0–3 are processed at edges T+1 through T+4.
- out_valid rises after edge T+4: latency is 4 cycles from acceptance.
- With out_ready held high, the output handshake occurs at edge T+5 and in_ready is high again after T+5.
- Maximum throughput is one operation per 6 cycles when in_valid is asserted immediately after in_ready returns.
- While out_ready=0, diff, bout, ovf, zero and out_valid hold steady indefinitely.
- in_ready is 0 from the edge after acceptance until the edge that completes the output handshake.

## Test plan
- a=16'h0000, b=16'h0001, bin=0 → diff=16'hFFFF, bout=1, ovf=0, zero=0. out_valid appears exactly 4 cycles after acceptance.
- a=16'h8000, b=16'h0001, bin=0 → diff=16'h7FFF, bout=0, ovf=1, zero=0.
- a=16'h1234, b=16'h1234, bin=0 → diff=16'h0000, zero=1, bout=0. Repeat with bin=1 → diff=16'hFFFF, bout=1, zero=0.
- a=16'hFFFF, b=16'h0001, bin=1 → diff=16'hFFFD, bout=0. Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0, and an in_valid pulse during this window is ignored.
- Accept a=16'h00F0, b=16'h000F, then assert rst after edge T+2 → next cycle out_valid=0, diff=0, in_ready=1. A new operation accepted afterwards gives its correct result (16'h5555 − 16'h1111 → 16'h4444).
- Back-to-back operations with out_ready=1 and in_valid held high → one result every 6 cycles, each checked against a reference model over 1000 random operand/bin sets.
